// File: rtl/wired_rob_alloc_pkg.sv
// Shared types and helpers for the ROB allocation stage: id type, lane payload, lane popcount.
package wired_rob_alloc_pkg;

    localparam int unsigned ROB_DEPTH_DFLT = 32;
    localparam int unsigned ROB_IDW        = $clog2(ROB_DEPTH_DFLT);
    localparam int unsigned LANES          = 2;

    typedef logic [ROB_IDW-1:0] rob_id_t;

    // Per-lane control package handed from the frontend FIFO to dispatch.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  fu;
        logic        pred_taken;
    } pipeline_ctrl_pack_t;

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return 2'(m[0]) + 2'(m[1]);
    endfunction

endpackage

// File: rtl/wired_rob_alloc.sv
// ROB allocation stage: tags each valid lane with a circular ROB index, stalls on
// insufficient space and hands the tagged package to dispatch through one output register.
module wired_rob_alloc
    import wired_rob_alloc_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DFLT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush_i,
    input  logic                                pkg_valid_i,
    output logic                                pkg_ready_o,
    input  logic [1:0]                          pkg_mask_i,
    input  pipeline_ctrl_pack_t [1:0]           pkg_i,
    output logic                                dis_valid_o,
    input  logic                                dis_ready_i,
    output logic [1:0]                          dis_mask_o,
    output pipeline_ctrl_pack_t [1:0]           dis_o,
    output logic [1:0][$clog2(ROB_DEPTH)-1:0]   dis_rob_id_o,
    input  logic [1:0]                          cmt_num_i,
    output logic [$clog2(ROB_DEPTH)-1:0]        rob_head_o,
    output logic [$clog2(ROB_DEPTH):0]          rob_cnt_o
);

    localparam int unsigned IDW = $clog2(ROB_DEPTH);
    localparam int unsigned CW  = IDW + 1;

    logic [IDW-1:0]             head_q, head_d;
    logic [IDW-1:0]             tail_q, tail_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       dv_q, dv_d;
    logic [1:0]                 dmask_q, dmask_d;
    pipeline_ctrl_pack_t [1:0]  dpay_q, dpay_d;
    logic [1:0][IDW-1:0]        did_q, did_d;

    logic [1:0]                 need;
    logic [CW-1:0]              free_slots;
    logic [CW-1:0]              alloc;
    logic                       acc;
    logic                       load;

    // Space check uses the registered count only; same-cycle commits help next cycle.
    always_comb begin
        need        = popcount2(pkg_mask_i);
        free_slots  = CW'(ROB_DEPTH) - cnt_q;
        pkg_ready_o = !rst && !flush_i && (!dv_q || dis_ready_i)
                      && (free_slots >= CW'(need));
        acc         = pkg_valid_i && pkg_ready_o;
        load        = acc && (need != 2'd0);
        alloc       = acc ? CW'(need) : '0;
    end

    // Pointer, count and output-register next state; flush overrides everything.
    always_comb begin
        head_d  = head_q + IDW'(cmt_num_i);
        tail_d  = tail_q + IDW'(alloc);
        cnt_d   = cnt_q + alloc - CW'(cmt_num_i);
        dv_d    = dv_q;
        dmask_d = dmask_q;
        dpay_d  = dpay_q;
        did_d   = did_q;

        if (load) begin
            dv_d     = 1'b1;
            dmask_d  = pkg_mask_i;
            dpay_d   = pkg_i;
            // Lane 1 follows lane 0 only when lane 0 actually took an entry.
            did_d[0] = tail_q;
            did_d[1] = tail_q + IDW'(pkg_mask_i[0]);
        end else if (dis_ready_i) begin
            dv_d = 1'b0;
        end

        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            dv_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            dv_q    <= 1'b0;
            dmask_q <= '0;
            dpay_q  <= '0;
            did_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            dv_q    <= dv_d;
            dmask_q <= dmask_d;
            dpay_q  <= dpay_d;
            did_q   <= did_d;
        end
    end

    // Backend must never retire more than is live, nor signal 3.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            assert (cmt_num_i != 2'd3);
            assert (CW'(cmt_num_i) <= cnt_q);
        end
    end

    assign dis_valid_o  = dv_q;
    assign dis_mask_o   = dmask_q;
    assign dis_o        = dpay_q;
    assign dis_rob_id_o = did_q;
    assign rob_head_o   = head_q;
    assign rob_cnt_o    = cnt_q;

endmodule
